decode_stage: RTL and testbench

- Second pipeline stage. Consumes the FE/DE latch (PC, IR, fetch-stall flag, lock).
- Decodes IR fields, reads the register file, and tracks in-flight destination writes with a per-register scoreboard.
- Drives the DE/EX latch.
- Generates the dependency-stall and branch-stall feedback consumed by the fetch stage.

---
 rtl/decode_pkg.sv | 65 ++++++
 rtl/decode_scoreboard.sv | 65 ++++++
 rtl/decode_stage.sv | 169 ++++++++++++++++
 tb/tb_decode_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, instruction classes and IR field positions.
// Also supplies default `PC_WIDTH / `IR_WIDTH when the build does not define them.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif

package decode_pkg;

  localparam logic [7:0] NOP_OPCODE = 8'hFF;
  localparam logic [7:0] OP_LDW     = 8'h80;
  localparam logic [7:0] OP_STW     = 8'h81;
  localparam logic [7:0] OP_JMP     = 8'hD0;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 24;
  localparam int DST_MSB  = 23;
  localparam int DST_LSB  = 20;
  localparam int SRC1_LSB = 16;
  localparam int SRC2_LSB = 12;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LDW,
    CLS_STW,
    CLS_BR,
    CLS_JMP
  } instr_class_e;

  // Unassigned opcodes fall through to CLS_NOP.
  function automatic instr_class_e opcode_class(input logic [7:0] opcode);
    instr_class_e cls;
    cls = CLS_NOP;
    if (opcode[7:6] == 2'b00)      cls = CLS_ALU_R;
    else if (opcode[7:6] == 2'b01) cls = CLS_ALU_I;
    else if (opcode == OP_LDW)     cls = CLS_LDW;
    else if (opcode == OP_STW)     cls = CLS_STW;
    else if (opcode[7:4] == 4'hC)  cls = CLS_BR;
    else if (opcode == OP_JMP)     cls = CLS_JMP;
    return cls;
  endfunction

  function automatic logic cls_reads_src1(input instr_class_e cls);
    return cls != CLS_NOP;
  endfunction

  function automatic logic cls_reads_src2(input instr_class_e cls);
    return (cls == CLS_ALU_R) || (cls == CLS_STW) || (cls == CLS_BR);
  endfunction

  function automatic logic cls_writes_dst(input instr_class_e cls);
    return (cls == CLS_ALU_R) || (cls == CLS_ALU_I) || (cls == CLS_LDW);
  endfunction

  function automatic logic cls_is_branch(input instr_class_e cls);
    return (cls == CLS_BR) || (cls == CLS_JMP);
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register in-flight writer counters with saturating increment (issue) and
// decrement (writeback); simultaneous inc/dec on one register leaves it unchanged.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter  int NUM_REGS     = 16,
  parameter  int MAX_INFLIGHT = 3,
  localparam int IDX_W        = $clog2(NUM_REGS),
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_en_i,
  input  logic [IDX_W-1:0] inc_idx_i,
  input  logic             dec_en_i,
  input  logic [IDX_W-1:0] dec_idx_i,
  input  logic [IDX_W-1:0] q1_idx_i,
  input  logic [IDX_W-1:0] q2_idx_i,
  output logic [CNT_W-1:0] q1_cnt_o,
  output logic [CNT_W-1:0] q2_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc      = inc_en_i && (inc_idx_i == IDX_W'(r));
      dec      = dec_en_i && (dec_idx_i == IDX_W'(r));
      cnt_d[r] = cnt_q[r];
      if (clear_i)                             cnt_d[r] = '0;
      else if (inc && !dec && cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + 1'b1;
      else if (dec && !inc && cnt_q[r] != '0)      cnt_d[r] = cnt_q[r] - 1'b1;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign q1_cnt_o = cnt_q[q1_idx_i];
  assign q2_cnt_o = cnt_q[q2_idx_i];

`ifndef SYNTHESIS
  always @(negedge clk_i) begin
    if (rst_ni && !clear_i) begin
      assert (!(dec_en_i && cnt_q[dec_idx_i] == '0))
        else $error("scoreboard: writeback to register %0d with no writer in flight", dec_idx_i);
      assert (!(inc_en_i && cnt_q[inc_idx_i] == CNT_MAX && !(dec_en_i && dec_idx_i == inc_idx_i)))
        else $error("scoreboard: writer count saturated on register %0d", inc_idx_i);
    end
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, register file read, scoreboard-based RAW stall and branch stall.
// Optional DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  I_CLOCK,
  input  logic                  I_RESET_N,
  input  logic                  I_LOCK,
  input  logic [`PC_WIDTH-1:0]  I_PC,
  input  logic [`IR_WIDTH-1:0]  I_IR,
  input  logic                  I_FetchStall,
  input  logic                  I_WBEnable,
  input  logic [3:0]            I_WBDestRegIdx,
  input  logic [DATA_WIDTH-1:0] I_WBValue,
  input  logic                  I_BranchAddrSelect,
  output logic                  O_LOCK,
  output logic [`PC_WIDTH-1:0]  O_PC,
  output logic [7:0]            O_Opcode,
  output logic [3:0]            O_DestRegIdx,
  output logic [DATA_WIDTH-1:0] O_Src1Value,
  output logic [DATA_WIDTH-1:0] O_Src2Value,
  output logic [DATA_WIDTH-1:0] O_Imm,
  output logic                  O_DEStall,
  output logic                  O_DepStallSignal,
  output logic                  O_BranchStallSignal
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [7:0]       opcode;
  instr_class_e     cls;
  logic [IDX_W-1:0] src1_idx, src2_idx, dst_idx, wb_idx;
  logic [CNT_W-1:0] src1_cnt, src2_cnt;
  logic             src1_busy, src2_busy;
  logic [DATA_WIDTH-1:0] src1_val, src2_val;
  logic             valid, dep, issue;

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];

  logic                  bp_q, bp_d;
  logic                  lock_q, lock_d;
  logic [`PC_WIDTH-1:0]  pc_q, pc_d;
  logic [7:0]            opc_q, opc_d;
  logic [3:0]            dst_q, dst_d;
  logic [DATA_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, imm_q, imm_d;
  logic                  destall_q, destall_d;

  assign opcode   = I_IR[OPC_MSB:OPC_LSB];
  assign cls      = opcode_class(opcode);
  assign src1_idx = I_IR[SRC1_LSB +: IDX_W];
  assign src2_idx = I_IR[SRC2_LSB +: IDX_W];
  assign dst_idx  = I_IR[DST_LSB +: IDX_W];
  assign wb_idx   = I_WBDestRegIdx[IDX_W-1:0];

  decode_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_sb (
    .clk_i     (I_CLOCK),
    .rst_ni    (I_RESET_N),
    .clear_i   (!I_LOCK),
    .inc_en_i  (issue && cls_writes_dst(cls)),
    .inc_idx_i (dst_idx),
    .dec_en_i  (I_WBEnable),
    .dec_idx_i (wb_idx),
    .q1_idx_i  (src1_idx),
    .q2_idx_i  (src2_idx),
    .q1_cnt_o  (src1_cnt),
    .q2_cnt_o  (src2_cnt)
  );

`ifdef DECODE_WB_BYPASS_EN
  // A lone in-flight writer retiring this very cycle no longer blocks; its data is forwarded.
  logic src1_fwd, src2_fwd;
  assign src1_fwd  = I_WBEnable && (wb_idx == src1_idx);
  assign src2_fwd  = I_WBEnable && (wb_idx == src2_idx);
  assign src1_busy = (src1_cnt != '0) && !(src1_fwd && src1_cnt == CNT_W'(1));
  assign src2_busy = (src2_cnt != '0) && !(src2_fwd && src2_cnt == CNT_W'(1));
  assign src1_val  = src1_fwd ? I_WBValue : rf_q[src1_idx];
  assign src2_val  = src2_fwd ? I_WBValue : rf_q[src2_idx];
`else
  assign src1_busy = (src1_cnt != '0);
  assign src2_busy = (src2_cnt != '0);
  assign src1_val  = rf_q[src1_idx];
  assign src2_val  = rf_q[src2_idx];
`endif

  // A resolving branch discards whatever fetch presents in the same cycle.
  assign valid = I_LOCK && !I_FetchStall && !bp_q && !I_BranchAddrSelect;
  assign dep   = valid && ((cls_reads_src1(cls) && src1_busy) ||
                           (cls_reads_src2(cls) && src2_busy));
  assign issue = valid && !dep;

  assign O_DepStallSignal    = dep;
  assign O_BranchStallSignal = bp_q || (issue && cls_is_branch(cls));

  always_comb begin
    lock_d    = I_LOCK;
    pc_d      = pc_q;
    opc_d     = NOP_OPCODE;
    dst_d     = dst_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    imm_d     = imm_q;
    destall_d = 1'b1;
    bp_d      = bp_q;
    if (!I_LOCK) begin
      bp_d = 1'b0;
    end else if (issue) begin
      pc_d      = I_PC;
      opc_d     = opcode;
      dst_d     = I_IR[DST_MSB:DST_LSB];
      s1_d      = src1_val;
      s2_d      = src2_val;
      imm_d     = DATA_WIDTH'(I_IR[IMM_MSB:IMM_LSB]);
      destall_d = 1'b0;
      bp_d      = cls_is_branch(cls);
    end else if (I_BranchAddrSelect) begin
      bp_d = 1'b0;
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      bp_q      <= 1'b0;
      lock_q    <= 1'b0;
      pc_q      <= '0;
      opc_q     <= NOP_OPCODE;
      dst_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      imm_q     <= '0;
      destall_q <= 1'b1;
    end else begin
      bp_q      <= bp_d;
      lock_q    <= lock_d;
      pc_q      <= pc_d;
      opc_q     <= opc_d;
      dst_q     <= dst_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      imm_q     <= imm_d;
      destall_q <= destall_d;
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
    end else if (I_WBEnable) begin
      rf_q[wb_idx] <= I_WBValue;
    end
  end

  assign O_LOCK       = lock_q;
  assign O_PC         = pc_q;
  assign O_Opcode     = opc_q;
  assign O_DestRegIdx = dst_q;
  assign O_Src1Value  = s1_q;
  assign O_Src2Value  = s2_q;
  assign O_Imm        = imm_q;
  assign O_DEStall    = destall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table vectors, directed corner sequences and random traffic
// against a behavioural model of the decode rules.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif

module tb_decode_stage;

  localparam int PCW = `PC_WIDTH;
  localparam int IRW = `IR_WIDTH;
  localparam int DW  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           lock, fs, wb_en, bas;
  logic [PCW-1:0] pc;
  logic [IRW-1:0] ir;
  logic [3:0]     wb_idx;
  logic [DW-1:0]  wb_val;
  logic           o_lock, o_destall, o_dep, o_brs;
  logic [PCW-1:0] o_pc;
  logic [7:0]     o_opc;
  logic [3:0]     o_dst;
  logic [DW-1:0]  o_s1, o_s2, o_imm;

  always #5 clk = ~clk;

  decode_stage dut (
    .I_CLOCK             (clk),
    .I_RESET_N           (rst_n),
    .I_LOCK              (lock),
    .I_PC                (pc),
    .I_IR                (ir),
    .I_FetchStall        (fs),
    .I_WBEnable          (wb_en),
    .I_WBDestRegIdx      (wb_idx),
    .I_WBValue           (wb_val),
    .I_BranchAddrSelect  (bas),
    .O_LOCK              (o_lock),
    .O_PC                (o_pc),
    .O_Opcode            (o_opc),
    .O_DestRegIdx        (o_dst),
    .O_Src1Value         (o_s1),
    .O_Src2Value         (o_s2),
    .O_Imm               (o_imm),
    .O_DEStall           (o_destall),
    .O_DepStallSignal    (o_dep),
    .O_BranchStallSignal (o_brs)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {K_NOP, K_ALUR, K_ALUI, K_LDW, K_STW, K_BR, K_JMP} kind_t;

  int             m_sb [16];
  logic [DW-1:0]  m_rf [16];
  bit             m_bp;
  logic           m_lock, m_destall;
  logic [PCW-1:0] m_pc;
  logic [7:0]     m_opc;
  logic [3:0]     m_dst;
  logic [DW-1:0]  m_s1, m_s2, m_imm;
  bit             m_dep, m_brs, m_issue;
  logic           last_dep, last_brs;

  function automatic kind_t kind_of(input int op);
    if (op < 64)               return K_ALUR;
    if (op < 128)              return K_ALUI;
    if (op == 128)             return K_LDW;
    if (op == 129)             return K_STW;
    if (op >= 192 && op < 208) return K_BR;
    if (op == 208)             return K_JMP;
    return K_NOP;
  endfunction

  function automatic bit rd1(input kind_t k); return k != K_NOP; endfunction
  function automatic bit rd2(input kind_t k); return k inside {K_ALUR, K_STW, K_BR}; endfunction
  function automatic bit wr(input kind_t k);  return k inside {K_ALUR, K_ALUI, K_LDW}; endfunction
  function automatic bit isbr(input kind_t k); return k inside {K_BR, K_JMP}; endfunction

  function automatic bit m_busy(input int r);
    if (m_sb[r] == 0) return 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    if (m_sb[r] == 1 && wb_en && int'(wb_idx) == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] m_operand(input int r);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && int'(wb_idx) == r) return wb_val;
`endif
    return m_rf[r];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_sb[r] = 0;
      m_rf[r] = '0;
    end
    m_bp = 0; m_lock = 0; m_pc = '0; m_opc = 8'hFF; m_dst = '0;
    m_s1 = '0; m_s2 = '0; m_imm = '0; m_destall = 1;
  endtask

  task automatic model_eval();
    kind_t k;
    bit    v;
    k       = kind_of(int'(ir[31:24]));
    v       = lock && !fs && !m_bp && !bas;
    m_dep   = v && ((rd1(k) && m_busy(int'(ir[19:16]))) || (rd2(k) && m_busy(int'(ir[15:12]))));
    m_issue = v && !m_dep;
    m_brs   = m_bp || (m_issue && isbr(k));
  endtask

  task automatic model_commit();
    kind_t k;
    int    d;
    k      = kind_of(int'(ir[31:24]));
    d      = int'(ir[23:20]);
    m_lock = lock;
    if (!lock) begin
      for (int r = 0; r < 16; r++) m_sb[r] = 0;
      m_bp = 0; m_destall = 1; m_opc = 8'hFF;
    end else begin
      if (wb_en && m_sb[wb_idx] > 0) m_sb[wb_idx]--;
      if (m_issue) begin
        m_pc = pc; m_opc = ir[31:24]; m_dst = ir[23:20];
        m_s1 = m_operand(int'(ir[19:16])); m_s2 = m_operand(int'(ir[15:12]));
        m_imm = ir[15:0]; m_destall = 0;
        if (wr(k) && m_sb[d] < 3) m_sb[d]++;
        if (isbr(k)) m_bp = 1;
      end else begin
        m_destall = 1; m_opc = 8'hFF;
        if (bas) m_bp = 0;
      end
    end
    if (wb_en) m_rf[wb_idx] = wb_val;
  endtask

  task automatic compare_regs();
    check("O_LOCK", o_lock, m_lock);
    check("O_PC", o_pc, m_pc);
    check("O_Opcode", o_opc, m_opc);
    check("O_DestRegIdx", o_dst, m_dst);
    check("O_Src1Value", o_s1, m_s1);
    check("O_Src2Value", o_s2, m_s2);
    check("O_Imm", o_imm, m_imm);
    check("O_DEStall", o_destall, m_destall);
  endtask

  task automatic step(input logic l, input logic [IRW-1:0] i_ir, input logic f,
                      input logic w, input logic [3:0] wi, input logic [DW-1:0] wv, input logic b);
    @(posedge clk); #1;
    lock = l; ir = i_ir; fs = f; wb_en = w; wb_idx = wi; wb_val = wv; bas = b;
    pc = PCW'($urandom);
    #1;
    model_eval();
    last_dep = o_dep;
    last_brs = o_brs;
    check("O_DepStallSignal", o_dep, m_dep);
    check("O_BranchStallSignal", o_brs, m_brs);
    @(negedge clk);
    model_commit();
    #1;
    compare_regs();
  endtask

  function automatic logic [IRW-1:0] mk(input logic [7:0] op, input logic [3:0] d,
                                        input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 12'h5A3};
  endfunction

  typedef struct {
    logic           lock;
    logic [IRW-1:0] ir;
    logic           fs, wb;
    logic [3:0]     wi;
    logic [DW-1:0]  wv;
    logic           bas;
    logic           e_dep, e_brs, e_destall;
    logic [7:0]     e_opc;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic           l, f, w, b;
    logic [7:0]     op;
    logic [3:0]     d, wi;
    int             sel, st;

    tbl[0]  = '{1'b0, mk(8'hFF,0,0,0), 0, 0, 4'd0, 16'h0,    0, 0, 0, 1, 8'hFF};
    tbl[1]  = '{1'b1, mk(8'h00,4,1,2), 0, 0, 4'd0, 16'h0,    0, 0, 0, 0, 8'h00};
    tbl[2]  = '{1'b1, mk(8'h45,7,4,0), 1, 0, 4'd0, 16'h0,    0, 0, 0, 1, 8'hFF};
    tbl[3]  = '{1'b1, mk(8'h45,7,4,0), 0, 0, 4'd0, 16'h0,    0, 1, 0, 1, 8'hFF};
    tbl[4]  = '{1'b1, mk(8'hFF,0,0,0), 0, 1, 4'd4, 16'h5555, 0, 0, 0, 0, 8'hFF};
    tbl[5]  = '{1'b1, mk(8'h45,7,4,0), 0, 0, 4'd0, 16'h0,    0, 0, 0, 0, 8'h45};
    tbl[6]  = '{1'b1, mk(8'hD0,0,7,0), 0, 0, 4'd0, 16'h0,    0, 1, 0, 1, 8'hFF};
    tbl[7]  = '{1'b1, mk(8'hD0,0,1,0), 0, 0, 4'd0, 16'h0,    0, 0, 1, 0, 8'hD0};
    tbl[8]  = '{1'b1, mk(8'h80,8,1,0), 0, 0, 4'd0, 16'h0,    0, 0, 1, 1, 8'hFF};
    tbl[9]  = '{1'b1, mk(8'h80,8,1,0), 0, 0, 4'd0, 16'h0,    1, 0, 1, 1, 8'hFF};
    tbl[10] = '{1'b1, mk(8'h80,8,1,0), 0, 0, 4'd0, 16'h0,    0, 0, 0, 0, 8'h80};
    tbl[11] = '{1'b1, mk(8'h90,9,8,8), 0, 0, 4'd0, 16'h0,    0, 0, 0, 0, 8'h90};
    tbl[12] = '{1'b1, mk(8'h81,0,8,7), 0, 0, 4'd0, 16'h0,    0, 1, 0, 1, 8'hFF};
    tbl[13] = '{1'b1, mk(8'hC5,0,2,3), 0, 0, 4'd0, 16'h0,    0, 0, 1, 0, 8'hC5};
    tbl[14] = '{1'b1, mk(8'hFF,0,0,0), 0, 0, 4'd0, 16'h0,    1, 0, 1, 1, 8'hFF};

    // reset values
    rst_n = 0; lock = 0; fs = 0; wb_en = 0; bas = 0; wb_idx = 0; wb_val = 0;
    pc = '0; ir = mk(8'hFF,0,0,0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset O_DEStall", o_destall, 1'b1);
    check("reset O_Opcode", o_opc, 8'hFF);
    check("reset O_LOCK", o_lock, 1'b0);
    check("reset O_PC", o_pc, '0);
    check("reset O_Src1Value", o_s1, '0);
    check("reset O_Imm", o_imm, '0);
    check("reset O_BranchStallSignal", o_brs, 1'b0);
    rst_n = 1;

    // table vectors
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].lock, tbl[i].ir, tbl[i].fs, tbl[i].wb, tbl[i].wi, tbl[i].wv, tbl[i].bas);
      check($sformatf("tbl%0d dep", i), last_dep, tbl[i].e_dep);
      check($sformatf("tbl%0d brstall", i), last_brs, tbl[i].e_brs);
      check($sformatf("tbl%0d destall", i), o_destall, tbl[i].e_destall);
      check($sformatf("tbl%0d opcode", i), o_opc, tbl[i].e_opc);
    end

    // RAW stall on r2 resolved by writeback of 0x1234
    step(1, mk(8'h00,2,0,0), 0, 0, 0, 0, 0);
    step(1, mk(8'h40,6,2,0), 0, 0, 0, 0, 0);
    check("raw stall", last_dep, 1'b1);
    step(1, mk(8'h40,6,2,0), 0, 0, 0, 0, 0);
    check("raw stall hold", last_dep, 1'b1);
    step(1, mk(8'h40,6,2,0), 0, 1, 4'd2, 16'h1234, 0);
`ifdef DECODE_WB_BYPASS_EN
    check("raw wb cycle dep", last_dep, 1'b0);
`else
    check("raw wb cycle dep", last_dep, 1'b1);
    step(1, mk(8'h40,6,2,0), 0, 0, 0, 0, 0);
    check("raw after wb dep", last_dep, 1'b0);
`endif
    check("raw operand", o_s1, 16'h1234);

    // branch: stall, bubbles, resolve, next instruction issues
    step(1, mk(8'hC0,0,0,1), 0, 0, 0, 0, 0);
    check("br stall", last_brs, 1'b1);
    check("br issued", o_destall, 1'b0);
    step(1, mk(8'hFF,0,0,0), 1, 0, 0, 0, 0);
    check("br bubble stall", last_brs, 1'b1);
    check("br bubble destall", o_destall, 1'b1);
    step(1, mk(8'h40,9,0,0), 0, 0, 0, 0, 1);
    check("br resolve stall", last_brs, 1'b1);
    check("br resolve discard", o_destall, 1'b1);
    step(1, mk(8'h40,9,0,0), 0, 0, 0, 0, 0);
    check("br released", last_brs, 1'b0);
    check("br next opcode", o_opc, 8'h40);

    // concurrent increment and decrement on r5
    step(1, mk(8'h00,5,0,0), 0, 0, 0, 0, 0);
    step(1, mk(8'h00,5,0,0), 0, 1, 4'd5, 16'h0F0F, 0);
    step(1, mk(8'h81,0,5,5), 0, 0, 0, 0, 0);
    check("concurrent sb reader stalls", last_dep, 1'b1);
    step(1, mk(8'h81,0,5,5), 0, 1, 4'd5, 16'hBEEF, 0);
    step(1, mk(8'h81,0,5,5), 0, 0, 0, 0, 0);
    check("concurrent drained", last_dep, 1'b0);
    check("concurrent operand", o_s1, 16'hBEEF);

    // lock low clears scoreboard but keeps register contents
    step(1, mk(8'h00,1,0,0), 0, 0, 0, 0, 0);
    step(1, mk(8'hFF,0,0,0), 0, 1, 4'd1, 16'h00AA, 0);
    step(1, mk(8'h00,2,0,0), 0, 0, 0, 0, 0);
    step(0, mk(8'h00,3,0,0), 0, 0, 0, 0, 0);
    check("lock low O_LOCK", o_lock, 1'b0);
    check("lock low destall", o_destall, 1'b1);
    step(1, mk(8'h81,0,1,2), 0, 0, 0, 0, 0);
    check("lock sb cleared", last_dep, 1'b0);
    check("lock rf kept", o_s1, 16'h00AA);

    // bubble pass-through leaves scoreboard alone
    step(1, mk(8'h00,4,1,1), 1, 0, 0, 0, 0);
    check("bubble destall", o_destall, 1'b1);
    check("bubble opcode", o_opc, 8'hFF);
    step(1, mk(8'h81,0,4,4), 0, 0, 0, 0, 0);
    check("bubble no sb", last_dep, 1'b0);

    // asynchronous reset with branch pending and sb[3]=2
    step(1, mk(8'h00,3,0,0), 0, 0, 0, 0, 0);
    step(1, mk(8'h00,3,0,0), 0, 0, 0, 0, 0);
    step(1, mk(8'hC0,0,0,0), 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    ir = mk(8'hFF,0,0,0); fs = 0; wb_en = 0; bas = 0; lock = 1;
    rst_n = 0;
    #1;
    check("midreset destall", o_destall, 1'b1);
    check("midreset opcode", o_opc, 8'hFF);
    check("midreset dep", o_dep, 1'b0);
    check("midreset brstall", o_brs, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    step(1, mk(8'h00,1,3,3), 0, 0, 0, 0, 0);
    check("post reset dep", last_dep, 1'b0);
    check("post reset issue", o_opc, 8'h00);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      l   = ($urandom_range(0, 19) != 0);
      f   = ($urandom_range(0, 4) == 0);
      b   = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    op = {2'b00, 6'($urandom)};
        2:       op = {2'b01, 6'($urandom)};
        3:       op = 8'h80;
        4, 9:    op = 8'h81;
        5:       op = {4'hC, 4'($urandom)};
        6:       op = 8'hD0;
        7:       op = 8'hFF;
        default: op = 8'($urandom);
      endcase
      d = 4'($urandom);
      if (wr(kind_of(int'(op))) && m_sb[d] >= 3) op = 8'hFF;
      w  = 0;
      wi = 0;
      if ($urandom_range(0, 4) < 2) begin
        st = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
          if (!w && m_sb[(st + k) % 16] > 0) begin
            w  = 1;
            wi = 4'((st + k) % 16);
          end
        end
      end
      step(l, {op, d, 4'($urandom), 4'($urandom), 12'($urandom)}, f, w, wi, 16'($urandom), b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
